// File: rtl/pwm_ramp_controller_if.sv
// pwm_ramp_controller_if: ramp request inputs and PWM/status outputs of pwm_ramp_controller.
// PWM_COMPLEMENTARY_EN adds the dead-banded complementary output pwm_out_n.
interface pwm_ramp_controller_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 enable;
    logic [CNT_WIDTH-1:0] target_duty;
    logic [CNT_WIDTH-1:0] duty;
    logic                 pwm_out;
    logic                 busy;
    logic                 at_target;
`ifdef PWM_COMPLEMENTARY_EN
    logic                 pwm_out_n;
    modport master (output enable, target_duty, input duty, pwm_out, busy, at_target, pwm_out_n);
    modport slave (input enable, target_duty, output duty, pwm_out, busy, at_target, pwm_out_n);
`else
    modport master (output enable, target_duty, input duty, pwm_out, busy, at_target);
    modport slave (input enable, target_duty, output duty, pwm_out, busy, at_target);
`endif
endinterface

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: PWM generator with soft-start/soft-stop duty ramping paced by clk_div edges.
// PWM_COMPLEMENTARY_EN adds a dead-banded complementary output.
module pwm_ramp_controller #(
    parameter int CNT_WIDTH = 8,
    parameter int STEP_SIZE = 1,
    parameter int DEAD_TIME = 4
) (
    input  logic                 clk_osc,
    input  logic                 rst,
    input  logic                 clk_div,
    pwm_ramp_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH:0]   STEP    = (CNT_WIDTH+1)'(STEP_SIZE);

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] pwm_cnt, cnt_next, duty_ramp, ramp_next, eff_tgt, duty, duty_eff;
    logic [CNT_WIDTH:0]   up_sum, dn_diff;
    logic                 clk_div_q, tick, pwm_out;

    assign tick     = clk_div & ~clk_div_q;
    assign eff_tgt  = bus.enable ? bus.target_duty : '0;
    assign up_sum   = {1'b0, duty_ramp} + STEP;
    assign dn_diff  = {1'b0, duty_ramp} - STEP;
    assign cnt_next = pwm_cnt + 1'b1;
    // the count about to start uses the duty loaded at the same wrap edge
    assign duty_eff = (pwm_cnt == CNT_MAX) ? duty_ramp : duty;

    assign bus.duty      = duty;
    assign bus.pwm_out   = pwm_out;
    assign bus.busy      = (state != IDLE);
    assign bus.at_target = (duty_ramp == eff_tgt);

    // the extra bit catches overshoot above the target and borrow below zero
    always_comb begin
        ramp_next = duty_ramp;
        if (duty_ramp < eff_tgt)
            ramp_next = (up_sum > {1'b0, eff_tgt}) ? eff_tgt : up_sum[CNT_WIDTH-1:0];
        else if (duty_ramp > eff_tgt)
            ramp_next = (dn_diff[CNT_WIDTH] || dn_diff < {1'b0, eff_tgt}) ? eff_tgt : dn_diff[CNT_WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        if (tick)
            case (state)
                IDLE:    state_next = (eff_tgt != '0) ? RAMP_UP : IDLE;
                RAMP_UP: state_next = (eff_tgt < duty_ramp) ? RAMP_DOWN :
                                      (ramp_next == eff_tgt) ? HOLD : RAMP_UP;
                HOLD:    state_next = (eff_tgt > duty_ramp) ? RAMP_UP :
                                      (eff_tgt < duty_ramp) ? RAMP_DOWN : HOLD;
                default: state_next = (eff_tgt > duty_ramp) ? RAMP_UP :
                                      (ramp_next != eff_tgt) ? RAMP_DOWN :
                                      (eff_tgt == '0) ? IDLE : HOLD;
            endcase
    end

    always_ff @(posedge clk_osc or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            duty_ramp <= '0;
            duty      <= '0;
            clk_div_q <= 1'b0;
            state     <= IDLE;
            pwm_out   <= 1'b0;
        end else begin
            clk_div_q <= clk_div;
            pwm_cnt   <= cnt_next;
            state     <= state_next;
            if (tick) duty_ramp <= ramp_next;
            if (pwm_cnt == CNT_MAX) duty <= duty_ramp;
            pwm_out   <= cnt_next < duty_eff;
        end
    end

`ifdef PWM_COMPLEMENTARY_EN
    localparam logic [CNT_WIDTH:0] DEAD = (CNT_WIDTH+1)'(DEAD_TIME);

    logic pwm_out_n;

    assign bus.pwm_out_n = pwm_out_n;

    // high only in [duty+DEAD, CNT_MAX-DEAD]; an empty window keeps it low
    always_ff @(posedge clk_osc or posedge rst) begin
        if (rst) pwm_out_n <= 1'b0;
        else pwm_out_n <= ({1'b0, cnt_next} >= {1'b0, duty_eff} + DEAD) &&
                          ({1'b0, cnt_next} + DEAD <= {1'b0, CNT_MAX});
    end
`else
    localparam int dead_time_unused = DEAD_TIME;
`endif
endmodule

// File: tb/tb_pwm_ramp_controller.sv
// tb_pwm_ramp_controller: directed plan plus random ramps on step-1 and step-3 instances,
// compared every cycle against a period/duty reference model.
module tb_pwm_ramp_controller;
    localparam int W = 8;
    localparam int PER = 256;
    localparam int DEAD = 4;
    localparam int S_IDLE = 0, S_UP = 1, S_HOLD = 2, S_DOWN = 3;

    int    steps [2] = '{1, 3};
    string names [2] = '{"s1", "s3"};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_div = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] target = '0;

    int n_checks = 0;
    int n_fail = 0;

    pwm_ramp_controller_if #(.CNT_WIDTH(W)) bus1 ();
    pwm_ramp_controller_if #(.CNT_WIDTH(W)) bus3 ();

    assign bus1.enable = enable;
    assign bus1.target_duty = target;
    assign bus3.enable = enable;
    assign bus3.target_duty = target;

    pwm_ramp_controller #(.CNT_WIDTH(W), .STEP_SIZE(1), .DEAD_TIME(DEAD)) u_dut1 (
        .clk_osc(clk), .rst(rst), .clk_div(clk_div), .bus(bus1));
    pwm_ramp_controller #(.CNT_WIDTH(W), .STEP_SIZE(3), .DEAD_TIME(DEAD)) u_dut3 (
        .clk_osc(clk), .rst(rst), .clk_div(clk_div), .bus(bus3));

    always #5 clk = ~clk;

    logic [W-1:0] o_duty [2];
    logic         o_pwm [2], o_busy [2], o_at [2], o_pwmn [2];

    assign o_duty[0] = bus1.duty;
    assign o_duty[1] = bus3.duty;
    assign o_pwm[0]  = bus1.pwm_out;
    assign o_pwm[1]  = bus3.pwm_out;
    assign o_busy[0] = bus1.busy;
    assign o_busy[1] = bus3.busy;
    assign o_at[0]   = bus1.at_target;
    assign o_at[1]   = bus3.at_target;
`ifdef PWM_COMPLEMENTARY_EN
    assign o_pwmn[0] = bus1.pwm_out_n;
    assign o_pwmn[1] = bus3.pwm_out_n;
`else
    assign o_pwmn[0] = 1'b0;
    assign o_pwmn[1] = 1'b0;
`endif

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: counter position, applied duty, ramp value and state per instance
    int m_cnt, m_div_q, m_eff, m_tick, m_wrap, nr;
    int m_ramp [2], m_duty [2], m_st [2], m_pwm [2], m_pwmn [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            m_div_q = 0;
            for (int k = 0; k < 2; k++) begin
                m_ramp[k] = 0; m_duty[k] = 0; m_st[k] = S_IDLE; m_pwm[k] = 0; m_pwmn[k] = 0;
            end
        end else begin
            m_tick = (clk_div && m_div_q == 0) ? 1 : 0;
            m_div_q = clk_div ? 1 : 0;
            m_eff = enable ? int'(target) : 0;
            m_wrap = (m_cnt == PER - 1) ? 1 : 0;
            m_cnt = (m_cnt + 1) % PER;
            for (int k = 0; k < 2; k++) begin
                if (m_wrap != 0) m_duty[k] = m_ramp[k];
                m_pwm[k] = (m_cnt < m_duty[k]) ? 1 : 0;
                m_pwmn[k] = (m_cnt >= m_duty[k] + DEAD && m_cnt <= PER - 1 - DEAD) ? 1 : 0;
                if (m_tick != 0) begin
                    if (m_ramp[k] < m_eff) nr = (m_ramp[k] + steps[k] < m_eff) ? m_ramp[k] + steps[k] : m_eff;
                    else if (m_ramp[k] > m_eff) nr = (m_ramp[k] - steps[k] > m_eff) ? m_ramp[k] - steps[k] : m_eff;
                    else nr = m_ramp[k];
                    if (m_st[k] == S_IDLE) begin
                        if (m_eff > 0) m_st[k] = S_UP;
                    end else if (m_st[k] == S_UP) begin
                        if (m_eff < m_ramp[k]) m_st[k] = S_DOWN;
                        else if (nr == m_eff) m_st[k] = S_HOLD;
                    end else if (m_st[k] == S_HOLD) begin
                        if (m_eff > m_ramp[k]) m_st[k] = S_UP;
                        else if (m_eff < m_ramp[k]) m_st[k] = S_DOWN;
                    end else begin
                        if (m_eff > m_ramp[k]) m_st[k] = S_UP;
                        else if (nr == m_eff) m_st[k] = (m_eff == 0) ? S_IDLE : S_HOLD;
                    end
                    m_ramp[k] = nr;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check({names[k], "_duty"}, int'(o_duty[k]), m_duty[k]);
            check({names[k], "_pwm"}, int'(o_pwm[k]), m_pwm[k]);
            check({names[k], "_busy"}, int'(o_busy[k]), (m_st[k] != S_IDLE) ? 1 : 0);
            check({names[k], "_at_target"}, int'(o_at[k]), ((enable ? int'(target) : 0) == m_ramp[k]) ? 1 : 0);
`ifdef PWM_COMPLEMENTARY_EN
            check({names[k], "_pwm_n"}, int'(o_pwmn[k]), m_pwmn[k]);
            check({names[k], "_no_overlap"}, int'(o_pwm[k] & o_pwmn[k]), 0);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int hi, input int lo);
        clk_div = 1'b1;
        cyc(hi);
        clk_div = 1'b0;
        cyc(lo);
    endtask

    task automatic period_high(input int k, output int hi, output int hin);
        @(negedge clk);
        while (m_cnt != 0) @(negedge clk);
        hi = 0;
        hin = 0;
        repeat (PER) begin
            hi += int'(o_pwm[k]);
            hin += int'(o_pwmn[k]);
            @(negedge clk);
        end
    endtask

    int hi, hin, d0;

    initial begin
        #1_000_000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            clk_div = ~clk_div;
            cyc(1);
        end
        check("reset_duty", int'(bus1.duty), 0);
        check("reset_busy", int'(bus1.busy), 0);
        check("reset_at_target", int'(bus1.at_target), 1);
        clk_div = 1'b0;
        rst = 1'b0;
        cyc(3);

        enable = 1'b1;
        target = 8'd4;
        for (int i = 1; i <= 4; i++) begin
            pulse(1, PER + 2);
            check("soft_start_duty", int'(bus1.duty), i);
            check("soft_start_busy", int'(bus1.busy), 1);
            check("soft_start_at_target", int'(bus1.at_target), (i == 4) ? 1 : 0);
        end
        period_high(0, hi, hin);
        check("soft_start_width", hi, 4);
`ifdef PWM_COMPLEMENTARY_EN
        check("comp_width_duty4", hin, PER - 2 * DEAD - 4);
`endif
        cyc(1);

        enable = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            pulse(1, PER + 2);
            check("soft_stop_duty", int'(bus1.duty), i);
            check("soft_stop_busy", int'(bus1.busy), (i == 0) ? 0 : 1);
        end
        period_high(0, hi, hin);
        check("soft_stop_width", hi, 0);
        cyc(1);

        enable = 1'b1;
        target = 8'd5;
        pulse(1, PER + 2);
        check("clamp_first", int'(bus3.duty), 3);
        check("clamp_at_target_1", int'(bus3.at_target), 0);
        pulse(1, PER + 2);
        check("clamp_second", int'(bus3.duty), 5);
        check("clamp_at_target_2", int'(bus3.at_target), 1);
        pulse(1, PER + 2);
        check("clamp_no_overshoot", int'(bus3.duty), 5);

        @(negedge clk);
        while (m_cnt != 100) @(negedge clk);
        d0 = int'(bus1.duty);
        check("glitch_start", d0, 3);
        clk_div = 1'b1;
        @(negedge clk);
        clk_div = 1'b0;
        while (m_cnt != 0) begin
            check("glitch_hold", int'(bus1.duty), d0);
            @(negedge clk);
        end
        check("glitch_apply", int'(bus1.duty), d0 + 1);
        period_high(0, hi, hin);
        check("glitch_width", hi, d0 + 1);
        cyc(1);

        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        target = 8'd8;
        pulse(1, PER + 2);
        pulse(1, PER + 2);
        check("mid_ramp_duty", int'(bus1.duty), 2);
        rst = 1'b1;
        enable = 1'b0;
        #1;
        check("mid_reset_duty", int'(bus1.duty), 0);
        check("mid_reset_pwm", int'(bus1.pwm_out), 0);
        check("mid_reset_busy", int'(bus1.busy), 0);
        check("mid_reset_at_target", int'(bus1.at_target), 1);
        cyc(3);
        rst = 1'b0;
        enable = 1'b1;
        pulse(1, PER + 2);
        check("restart_duty", int'(bus1.duty), 1);

`ifdef PWM_COMPLEMENTARY_EN
        target = 8'd10;
        for (int i = 0; i < 9; i++) pulse(1, 2);
        cyc(PER + 2);
        check("comp_duty10", int'(bus1.duty), 10);
        period_high(0, hi, hin);
        check("comp_width_duty10", hin, 251 - 14 + 1);
        cyc(1);
`endif

        for (int i = 0; i < 200; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) target = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 1) == 0) target = 8'($urandom_range(0, 12));
            pulse($urandom_range(1, 3), $urandom_range(1, 12));
            if (i % 50 == 49) cyc(PER);
        end
        enable = 1'b0;
        for (int i = 0; i < 100; i++) pulse(1, 1);
        cyc(PER + 2);
        check("final_busy_s1", int'(bus1.busy), 0);
        check("final_busy_s3", int'(bus3.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
